// File: rtl/serial_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_pkg
// Brief    : Shared types, defaults and helpers for the serial pattern
//            transmitter and the serial sequence-detector family.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pattern_pkg;

    // Transmitter states; PARITY is reachable only when parity is compiled in
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } spt_state_t;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 1;

    // Bits needed to hold values 0..max_count, never less than one bit
    function automatic int cnt_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spt_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : spt_down_counter
// Brief    : Loadable down counter with enable and terminal-count flag.
//            Load wins over enable; the count saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module spt_down_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Parallel load, otherwise count down while enabled until zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Brief    : Serial bit-stream source. Takes a WIDTH-bit word over a
//            valid/ready handshake, shifts it out MSB-first on x, then holds
//            x low for GAP_CYCLES cycles before accepting the next word.
//            Define SERIAL_PATTERN_TX_PARITY_EN to append one even-parity
//            bit after bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int c_bit_w = cnt_width(WIDTH - 1);
    localparam int c_gap_w = cnt_width(GAP_CYCLES);
    localparam logic [c_bit_w-1:0] c_bit_load = c_bit_w'(WIDTH - 1);
    localparam logic [c_gap_w-1:0] c_gap_load =
        c_gap_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit c_has_gap = (GAP_CYCLES > 0);

    spt_state_t       r_state;
    // MSB goes straight to x at the handshake, so only the lower bits are kept
    logic [WIDTH-2:0] r_shift;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             r_parity;
`endif

    logic w_bit_tc;
    logic w_gap_tc;
    logic w_bit_load;
    logic w_bit_en;
    logic w_gap_load;
    logic w_gap_en;

    // Counters are preloaded while outside their active state, so they hold
    // the full count on the first cycle of SHIFT / GAP
    assign w_bit_load = (r_state == S_IDLE);
    assign w_bit_en   = (r_state == S_SHIFT);
    assign w_gap_load = (r_state != S_GAP);
    assign w_gap_en   = (r_state == S_GAP);

    spt_down_counter #(
        .CNT_W (c_bit_w)
    ) u_bit_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_bit_load),
        .i_load_value (c_bit_load),
        .i_en         (w_bit_en),
        .o_tc         (w_bit_tc)
    );

    spt_down_counter #(
        .CNT_W (c_gap_w)
    ) u_gap_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_gap_load),
        .i_load_value (c_gap_load),
        .i_en         (w_gap_en),
        .o_tc         (w_gap_tc)
    );

    // Framing FSM: handshake, MSB-first shift, optional parity, then gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_x      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_shift  <= data_in[WIDTH-2:0];
                        r_x      <= data_in[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        r_parity <= ^data_in;
`endif
                    end
                end

                S_SHIFT: begin
                    if (w_bit_tc) begin
                        // bit 0 has been on x for a full cycle
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        r_x     <= r_parity;
                        r_state <= S_PARITY;
`else
                        r_x    <= 1'b0;
                        r_done <= 1'b1;
                        if (c_has_gap) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
`endif
                    end else begin
                        r_x     <= r_shift[WIDTH-2];
                        r_shift <= r_shift << 1;
                    end
                end

                S_PARITY: begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    r_x    <= 1'b0;
                    r_done <= 1'b1;
                    if (c_has_gap) begin
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
`else
                    r_x     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`endif
                end

                S_GAP: begin
                    if (w_gap_tc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_x     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign x     = r_x;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_tx
// Brief    : Directed self-checking bench for serial_pattern_tx
//            (WIDTH=8, GAP_CYCLES=1 and a second instance with GAP_CYCLES=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       x;
    logic       busy;
    logic       done;
    logic [7:0] data2;
    logic       valid2;
    logic       ready2;
    logic       x2;
    logic       busy2;
    logic       done2;

    int n_checks = 0;
    int n_errors = 0;

    serial_pattern_tx #(
        .WIDTH      (8),
        .GAP_CYCLES (1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .x       (x),
        .busy    (busy),
        .done    (done)
    );

    serial_pattern_tx #(
        .WIDTH      (8),
        .GAP_CYCLES (0)
    ) u_dut_nogap (
        .clk     (clk),
        .rst     (rst),
        .data_in (data2),
        .valid   (valid2),
        .ready   (ready2),
        .x       (x2),
        .busy    (busy2),
        .done    (done2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at a negedge with the DUT idle; ends on the first ready cycle
    task automatic run_word(input logic [7:0] w, input bit disturb, input string tag);
        data_in = w;
        valid   = 1'b1;
        tick;
        valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s bit%0d", tag, 7 - i), x, w[7-i]);
            check_eq($sformatf("%s done low c%0d", tag, i + 1), done, 1'b0);
            if (i == 0) begin
                check_eq($sformatf("%s ready low", tag), ready, 1'b0);
                check_eq($sformatf("%s busy high", tag), busy, 1'b1);
            end
            if (disturb) begin
                data_in = 8'h00;
                valid   = (i < 6) ? i[0] : 1'b0;
            end
            tick;
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        check_eq($sformatf("%s parity", tag), x, ^w);
        check_eq($sformatf("%s done before parity end", tag), done, 1'b0);
        tick;
`endif
        check_eq($sformatf("%s done pulse", tag), done, 1'b1);
        check_eq($sformatf("%s x in gap", tag), x, 1'b0);
        check_eq($sformatf("%s busy in gap", tag), busy, 1'b1);
        check_eq($sformatf("%s ready in gap", tag), ready, 1'b0);
        tick;
        check_eq($sformatf("%s ready back", tag), ready, 1'b1);
        check_eq($sformatf("%s done cleared", tag), done, 1'b0);
        check_eq($sformatf("%s busy cleared", tag), busy, 1'b0);
        check_eq($sformatf("%s x idle", tag), x, 1'b0);
    endtask

    initial begin
        int dcount;
        rst     = 1'b0;
        data_in = 8'hFF;
        valid   = 1'b1;
        data2   = 8'h00;
        valid2  = 1'b0;

        // Reset state, with valid asserted and ignored
        #69;
        check_eq("reset ready", ready, 1'b1);
        check_eq("reset x", x, 1'b0);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset done", done, 1'b0);
        valid = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);

        // Test 1: 8'hB2
        run_word(8'hB2, 1'b0, "t1 B2");

        // Test 2: back-to-back FF then 00, valid held high
        data_in = 8'hFF;
        valid   = 1'b1;
        tick;
        dcount = 0;
        for (int i = 1; i <= 20 + 2 * PAR; i++) begin
            check_eq($sformatf("t2 x c%0d", i), x, (i <= 8) ? 1 : 0);
            if (i == 10 + PAR) check_eq("t2 ready idle", ready, 1'b1);
            if (done) dcount++;
            if (i == 1) data_in = 8'h00;
            if (i == 11 + PAR) valid = 1'b0;
            tick;
        end
        check_eq("t2 done pulses", dcount, 2);
        check_eq("t2 ready after", ready, 1'b1);

        // Test 3: reset in the middle of 8'hA5
        data_in = 8'hA5;
        valid   = 1'b1;
        tick;
        valid = 1'b0;
        check_eq("t3 c1 x", x, 1'b1);
        tick;
        tick;
        check_eq("t3 c3 x", x, 1'b1);
        tick;
        check_eq("t3 busy before rst", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("t3 rst x", x, 1'b0);
        check_eq("t3 rst busy", busy, 1'b0);
        check_eq("t3 rst ready", ready, 1'b1);
        check_eq("t3 rst done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check_eq("t3 post done", done, 1'b0);
        check_eq("t3 post busy", busy, 1'b0);
        check_eq("t3 post x", x, 1'b0);
        run_word(8'h81, 1'b0, "t3 81");

        // Test 4: inputs disturbed during SHIFT of 8'hC3
        run_word(8'hC3, 1'b1, "t4 C3");
        tick;
        check_eq("t4 no queued word busy", busy, 1'b0);
        check_eq("t4 no queued word x", x, 1'b0);

        // Test 5: odd-weight word (parity 1 when enabled)
        run_word(8'h07, 1'b0, "t5 07");

        // Test 6: GAP_CYCLES=0, two FF words with valid held
        data2  = 8'hFF;
        valid2 = 1'b1;
        tick;
        for (int i = 1; i <= 17 + PAR; i++) begin
            check_eq($sformatf("t6 x c%0d", i), x2, (i == 9 || i == 9 + PAR) ? 0 : 1);
            check_eq($sformatf("t6 ready c%0d", i), ready2, (i == 9 + PAR) ? 1 : 0);
            if (i == 9 + PAR) begin
                check_eq("t6 done", done2, 1'b1);
                check_eq("t6 busy idle", busy2, 1'b0);
            end
            if (i == 10 + PAR) valid2 = 1'b0;
            tick;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
